// File: rtl/sle8_share_arbiter_if.sv
// Request/response bundle between the signed-compare requesters
// and the shared SLE8 arbiter.
interface sle8_share_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]   req;
    logic [8*N-1:0] a;
    logic [8*N-1:0] b;
    logic [N-1:0]   ack;
    logic           res;
    logic           res_valid;
    logic [IDW-1:0] res_id;

    modport master (
        output req, a, b,
        input  ack, res, res_valid, res_id
    );

    modport slave (
        input  req, a, b,
        output ack, res, res_valid, res_id
    );
endinterface

// File: rtl/sle8_share_arbiter.sv
// Round-robin arbiter sharing one subtract-based signed 8-bit
// less-or-equal comparator among N requesters.
module sle8_share_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input logic                clk,
    input logic                resetn,
    sle8_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] res_id_q;
    logic [7:0]     op_a;
    logic [7:0]     op_b;
    logic [7:0]     sel_a;
    logic [7:0]     sel_b;
    logic [7:0]     diff;
    logic           found;
    logic           cmp;
    logic           res_q;
    logic [N-1:0]   ack;

    // Search starts one past the last winner and wraps modulo N.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDW'((int'(last_grant) + k) % N);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (win == IDW'(i)) begin
                sel_a = bus.a[8*i +: 8];
                sel_b = bus.b[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (found) state_nx = ISSUE;
            ISSUE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= IDW'(N - 1);
            grant_id   <= '0;
            op_a       <= '0;
            op_b       <= '0;
            res_q      <= 1'b0;
            res_id_q   <= '0;
        end else begin
            if (state == IDLE && found) begin
                last_grant <= win;
                grant_id   <= win;
                op_a       <= sel_a;
                op_b       <= sel_b;
            end
            if (state == ISSUE) begin
                res_q    <= cmp;
                res_id_q <= grant_id;
            end
        end
    end

    // Sign-mismatch terms absorb the overflow of B - A.
    assign diff = op_b + ~op_a + 8'd1;
    assign cmp  = (op_a[7] & ~op_b[7])
                | (~(op_a[7] ^ op_b[7]) & ~diff[7]);

    always_comb begin
        ack = '0;
        if (state == RESP) ack[grant_id] = 1'b1;
    end

    assign bus.ack       = ack;
    assign bus.res       = res_q;
    assign bus.res_valid = (state == RESP);
    assign bus.res_id    = res_id_q;
endmodule
